// File: rtl/lattice_filter_cascade_pkg.sv
// Shared types and helpers for the lattice filter cascade: FSM states, sample width,
// coefficient address fields and the 16-bit saturator.
package lattice_filter_cascade_pkg;

  typedef enum logic [1:0] {IDLE, MAC1, MAC2, UPD} state_t;

  localparam int SAMPLE_W     = 16;
  localparam int SAT_IN_W     = 48;
  localparam int COEF_K_BIT   = 0;
  localparam int COEF_SEC_LSB = 1;
  localparam int COEF_SEC_MSB = 3;
  localparam int SEC_W        = COEF_SEC_MSB - COEF_SEC_LSB + 1;

  localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 32767;
  localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -32768;

  function automatic logic signed [SAMPLE_W-1:0] saturate16(input logic signed [SAT_IN_W-1:0] v);
    if (v > SAT_MAX) begin
      return 16'sh7fff;
    end else if (v < SAT_MIN) begin
      return 16'sh8000;
    end
    return v[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/lattice_filter_cascade_if.sv
// Sample, control and coefficient-write bundle of the filter cascade.
// Strobe has no ready: the filter raises overrun if a strobe lands while it is busy.
interface lattice_filter_cascade_if #(parameter int CW = 10) ();
  logic                 strobe;
  logic signed [15:0]   sample_in;
  logic                 clear;
  logic                 coef_wr;
  logic [3:0]           coef_addr;
  logic signed [CW-1:0] coef_data;
  logic signed [15:0]   sample_out;
  logic                 sample_valid;
  logic                 busy;
  logic                 overrun;

  modport master (
    output strobe, sample_in, clear, coef_wr, coef_addr, coef_data,
    input  sample_out, sample_valid, busy, overrun
  );

  modport slave (
    input  strobe, sample_in, clear, coef_wr, coef_addr, coef_data,
    output sample_out, sample_valid, busy, overrun
  );
endinterface

// File: rtl/lattice_filter_cascade_filter_mac.sv
// Shared multiply-accumulate: one product per enabled cycle, accumulator register, saturating shift.
// Latency 1 cycle per MAC step; no backpressure, the FSM sequences it.
module filter_mac
  import lattice_filter_cascade_pkg::*;
#(
  parameter int CW    = 10,
  parameter int CFRAC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mac_en,
  input  logic                       mac_first,
  input  logic signed [SAMPLE_W-1:0] x,
  input  logic signed [CW-1:0]       coef,
  input  logic signed [SAMPLE_W-1:0] y_tap,
  output logic signed [SAMPLE_W-1:0] y
);

  localparam int AW = SAMPLE_W + CW + 2;

  logic signed [AW-1:0] coef_ext, tap_ext, prod, base, acc, acc_shr;

  assign coef_ext = AW'(coef);
  assign tap_ext  = AW'(y_tap);
  assign prod     = coef_ext * tap_ext;
  // First step of a section seeds the accumulator with the scaled section input.
  assign base     = mac_first ? (AW'(x) <<< CFRAC) : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (mac_en) begin
      acc <= base + prod;
    end
  end

  assign acc_shr = acc >>> CFRAC;
  assign y       = saturate16(SAT_IN_W'(acc_shr));

endmodule

// File: rtl/lattice_filter_cascade.sv
// NSECT cascaded all-pole 2nd-order sections on one multiplier; sample_valid 3*NSECT edges after strobe.
// No backpressure: a strobe while busy is dropped and sets sticky overrun.
module lattice_filter_cascade
  import lattice_filter_cascade_pkg::*;
#(
  parameter int NSECT = 6,
  parameter int CW    = 10,
  parameter int CFRAC = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  lattice_filter_cascade_if.slave  bus
);

  state_t state, state_nxt;

  logic [SEC_W-1:0]           sec;
  logic [SEC_W-1:0]           wsec;
  logic signed [SAMPLE_W-1:0] x, y, y_tap, sample_out;
  logic signed [SAMPLE_W-1:0] y1 [NSECT];
  logic signed [SAMPLE_W-1:0] y2 [NSECT];
  logic signed [CW-1:0]       c1 [NSECT];
  logic signed [CW-1:0]       c2 [NSECT];
  logic signed [CW-1:0]       coef;
  logic                       start, last, mac_en, mac_first, overrun, sample_valid;

  assign start     = (state == IDLE) && bus.strobe && !bus.clear;
  assign last      = (sec == SEC_W'(NSECT - 1));
  assign wsec      = bus.coef_addr[COEF_SEC_MSB:COEF_SEC_LSB];
  assign mac_en    = (state == MAC1) || (state == MAC2);
  assign mac_first = (state == MAC1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.strobe) state_nxt = MAC1;
        MAC1:    state_nxt = MAC2;
        MAC2:    state_nxt = UPD;
        UPD:     state_nxt = last ? IDLE : MAC1;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    coef  = c1[sec];
    y_tap = y1[sec];
    if (state == MAC2) begin
      coef  = c2[sec];
      y_tap = y2[sec];
    end
  end

  filter_mac #(.CW(CW), .CFRAC(CFRAC)) u_mac (
    .clk       (clk),
    .rst       (rst),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .x         (x),
    .coef      (coef),
    .y_tap     (y_tap),
    .y         (y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec          <= '0;
      x            <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NSECT; i++) begin
        y1[i] <= '0;
        y2[i] <= '0;
        c1[i] <= '0;
        c2[i] <= '0;
      end
    end else begin
      sample_valid <= 1'b0;
      if (bus.coef_wr && (int'(wsec) < NSECT)) begin
        if (bus.coef_addr[COEF_K_BIT]) c2[wsec] <= bus.coef_data;
        else                           c1[wsec] <= bus.coef_data;
      end
      // Clear aborts the sample in flight, so it also suppresses the UPD writes below.
      if (bus.clear) begin
        overrun <= 1'b0;
        for (int i = 0; i < NSECT; i++) begin
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end else begin
        if (bus.strobe && (state != IDLE)) overrun <= 1'b1;
        if (start) begin
          x   <= bus.sample_in;
          sec <= '0;
        end
        if (state == UPD) begin
          y2[sec] <= y1[sec];
          y1[sec] <= y;
          x       <= y;
          if (last) begin
            sample_out   <= y;
            sample_valid <= 1'b1;
          end else begin
            sec <= sec + 1'b1;
          end
        end
      end
    end
  end

  assign bus.sample_out   = sample_out;
  assign bus.sample_valid = sample_valid;
  assign bus.busy         = (state != IDLE);
  assign bus.overrun      = overrun;

endmodule

// File: tb/tb_lattice_filter_cascade.sv
// Directed scoreboard bench for lattice_filter_cascade: expected outputs and arrival cycles are queued
// at stimulus time and checked by an independent monitor on every sample_valid.
module tb_lattice_filter_cascade;

  localparam int NSECT = 6;
  localparam int CW    = 10;
  localparam int CFRAC = 8;
  localparam int LAT   = 3 * NSECT;

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  lattice_filter_cascade_if #(.CW(CW)) bus_if ();

  lattice_filter_cascade #(.NSECT(NSECT), .CW(CW), .CFRAC(CFRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every valid must match the oldest queued expectation, value and cycle.
  always @(negedge clk) begin
    if (bus_if.sample_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", $signed(bus_if.sample_out), 99999);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sample_out", $signed(bus_if.sample_out), e.val);
        check("valid_cycle", cyc, e.cyc);
      end
    end
  end

  // All stimulus tasks are entered and left at a falling edge.
  task automatic send_exp(input int v, input int e);
    exp_q.push_back('{val: e, cyc: cyc + LAT + 1});
    bus_if.sample_in = 16'(v);
    bus_if.strobe    = 1'b1;
    @(negedge clk);
    bus_if.strobe    = 1'b0;
  endtask

  task automatic raw_strobe(input int v);
    bus_if.sample_in = 16'(v);
    bus_if.strobe    = 1'b1;
    @(negedge clk);
    bus_if.strobe    = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic run(input int v, input int e);
    send_exp(v, e);
    drain();
  endtask

  task automatic wr_coef(input logic [3:0] a, input int d);
    bus_if.coef_wr   = 1'b1;
    bus_if.coef_addr = a;
    bus_if.coef_data = CW'(d);
    @(negedge clk);
    bus_if.coef_wr   = 1'b0;
  endtask

  task automatic do_clear();
    bus_if.clear = 1'b1;
    @(negedge clk);
    bus_if.clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nb;
    bus_if.strobe    = 1'b0;
    bus_if.sample_in = '0;
    bus_if.clear     = 1'b0;
    bus_if.coef_wr   = 1'b0;
    bus_if.coef_addr = '0;
    bus_if.coef_data = '0;
    repeat (3) @(negedge clk);
    check("rst_sample_out", $signed(bus_if.sample_out), 0);
    check("rst_valid", int'(bus_if.sample_valid), 0);
    check("rst_busy", int'(bus_if.busy), 0);
    check("rst_overrun", int'(bus_if.overrun), 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero coefficients: straight passthrough, busy for the whole computation.
    send_exp(1000, 1000);
    nb = 0;
    repeat (LAT) begin
      if (bus_if.busy) nb++;
      @(negedge clk);
    end
    check("busy_cycles", nb, LAT);
    check("busy_after", int'(bus_if.busy), 0);
    check("overrun_clean", int'(bus_if.overrun), 0);
    drain();

    // Writes to sections beyond NSECT have no effect.
    wr_coef(4'b1100, 256);
    wr_coef(4'b1111, 256);
    run(-1234, -1234);

    // Section 0 integrator.
    do_clear();
    wr_coef(4'b0000, 256);
    run(100, 100);
    run(0, 100);
    run(0, 100);
    run(100, 200);

    // Saturation both ways.
    do_clear();
    run(32767, 32767);
    run(32767, 32767);
    do_clear();
    run(-32768, -32768);
    run(-32768, -32768);

    // Last-section integrator.
    wr_coef(4'b0000, 0);
    do_clear();
    wr_coef(4'b1010, 256);
    run(50, 50);
    run(0, 50);
    run(-20, 30);
    wr_coef(4'b1010, 0);

    // Resonator with truncating arithmetic shift.
    do_clear();
    wr_coef(4'b0000, 128);
    wr_coef(4'b0001, -64);
    run(1024, 1024);
    run(0, 512);
    run(0, 0);
    run(0, -128);
    run(0, -64);

    // Strobe while busy.
    do_clear();
    send_exp(500, 500);
    repeat (4) @(negedge clk);
    raw_strobe(7);
    check("overrun_set", int'(bus_if.overrun), 1);
    drain();
    repeat (25) @(negedge clk);
    check("overrun_sticky", int'(bus_if.overrun), 1);
    do_clear();
    check("overrun_cleared", int'(bus_if.overrun), 0);
    check("out_held_clear", $signed(bus_if.sample_out), 500);

    // Reset in mid computation.
    raw_strobe(700);
    repeat (2) @(negedge clk);
    raw_strobe(9);
    check("overrun_pre_rst", int'(bus_if.overrun), 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_sample_out", $signed(bus_if.sample_out), 0);
    check("midrst_busy", int'(bus_if.busy), 0);
    check("midrst_overrun", int'(bus_if.overrun), 0);
    rst = 1'b0;
    repeat (30) @(negedge clk);

    // Clear and strobe together: strobe dropped.
    bus_if.clear     = 1'b1;
    bus_if.strobe    = 1'b1;
    bus_if.sample_in = 16'sd123;
    @(negedge clk);
    bus_if.clear  = 1'b0;
    bus_if.strobe = 1'b0;
    check("clr_strobe_busy", int'(bus_if.busy), 0);
    check("clr_strobe_overrun", int'(bus_if.overrun), 0);
    repeat (25) @(negedge clk);

    // Reset zeroed coefficients: no residual feedback.
    run(300, 300);
    run(0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
